// File: rtl/axi_mux_w.sv
// axi_mux_w: AXI4 write-channel master multiplexer (4 masters -> 1 shared slave-side write bus).
// Ports: ACLK/ARESETn (async active-low); per master N=0..3: mN_wgrnt (one-hot grant from the
// write arbiter), AW/W inputs with AWREADY/WREADY outputs, B outputs with BREADY input;
// bus_AW*/bus_W* outputs with bus_AWREADY/bus_WREADY inputs, bus_B* inputs with bus_BREADY
// output; busy (state not IDLE); err_wlast (burst length mismatch pulse).
// Optional feature: define AXI_MUX_W_BEATCHK_EN to drive bus_WLAST from a beat counter checked
// against the latched AWLEN and to flag masters whose WLAST disagrees; otherwise err_wlast is 0.
module axi_mux_w #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    m0_wgrnt,
   input  logic [ID_WIDTH-1:0]     m0_AWID,
   input  logic [ADDR_WIDTH-1:0]   m0_AWADDR,
   input  logic [7:0]              m0_AWLEN,
   input  logic [2:0]              m0_AWSIZE,
   input  logic [1:0]              m0_AWBURST,
   input  logic                    m0_AWVALID,
   output logic                    m0_AWREADY,
   input  logic [DATA_WIDTH-1:0]   m0_WDATA,
   input  logic [DATA_WIDTH/8-1:0] m0_WSTRB,
   input  logic                    m0_WLAST,
   input  logic                    m0_WVALID,
   output logic                    m0_WREADY,
   output logic [ID_WIDTH-1:0]     m0_BID,
   output logic [1:0]              m0_BRESP,
   output logic                    m0_BVALID,
   input  logic                    m0_BREADY,
   input  logic                    m1_wgrnt,
   input  logic [ID_WIDTH-1:0]     m1_AWID,
   input  logic [ADDR_WIDTH-1:0]   m1_AWADDR,
   input  logic [7:0]              m1_AWLEN,
   input  logic [2:0]              m1_AWSIZE,
   input  logic [1:0]              m1_AWBURST,
   input  logic                    m1_AWVALID,
   output logic                    m1_AWREADY,
   input  logic [DATA_WIDTH-1:0]   m1_WDATA,
   input  logic [DATA_WIDTH/8-1:0] m1_WSTRB,
   input  logic                    m1_WLAST,
   input  logic                    m1_WVALID,
   output logic                    m1_WREADY,
   output logic [ID_WIDTH-1:0]     m1_BID,
   output logic [1:0]              m1_BRESP,
   output logic                    m1_BVALID,
   input  logic                    m1_BREADY,
   input  logic                    m2_wgrnt,
   input  logic [ID_WIDTH-1:0]     m2_AWID,
   input  logic [ADDR_WIDTH-1:0]   m2_AWADDR,
   input  logic [7:0]              m2_AWLEN,
   input  logic [2:0]              m2_AWSIZE,
   input  logic [1:0]              m2_AWBURST,
   input  logic                    m2_AWVALID,
   output logic                    m2_AWREADY,
   input  logic [DATA_WIDTH-1:0]   m2_WDATA,
   input  logic [DATA_WIDTH/8-1:0] m2_WSTRB,
   input  logic                    m2_WLAST,
   input  logic                    m2_WVALID,
   output logic                    m2_WREADY,
   output logic [ID_WIDTH-1:0]     m2_BID,
   output logic [1:0]              m2_BRESP,
   output logic                    m2_BVALID,
   input  logic                    m2_BREADY,
   input  logic                    m3_wgrnt,
   input  logic [ID_WIDTH-1:0]     m3_AWID,
   input  logic [ADDR_WIDTH-1:0]   m3_AWADDR,
   input  logic [7:0]              m3_AWLEN,
   input  logic [2:0]              m3_AWSIZE,
   input  logic [1:0]              m3_AWBURST,
   input  logic                    m3_AWVALID,
   output logic                    m3_AWREADY,
   input  logic [DATA_WIDTH-1:0]   m3_WDATA,
   input  logic [DATA_WIDTH/8-1:0] m3_WSTRB,
   input  logic                    m3_WLAST,
   input  logic                    m3_WVALID,
   output logic                    m3_WREADY,
   output logic [ID_WIDTH-1:0]     m3_BID,
   output logic [1:0]              m3_BRESP,
   output logic                    m3_BVALID,
   input  logic                    m3_BREADY,
   output logic [ID_WIDTH-1:0]     bus_AWID,
   output logic [ADDR_WIDTH-1:0]   bus_AWADDR,
   output logic [7:0]              bus_AWLEN,
   output logic [2:0]              bus_AWSIZE,
   output logic [1:0]              bus_AWBURST,
   output logic                    bus_AWVALID,
   input  logic                    bus_AWREADY,
   output logic [DATA_WIDTH-1:0]   bus_WDATA,
   output logic [DATA_WIDTH/8-1:0] bus_WSTRB,
   output logic                    bus_WLAST,
   output logic                    bus_WVALID,
   input  logic                    bus_WREADY,
   input  logic [ID_WIDTH-1:0]     bus_BID,
   input  logic [1:0]              bus_BRESP,
   input  logic                    bus_BVALID,
   output logic                    bus_BREADY,
   output logic                    busy,
   output logic                    err_wlast
);
   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
   state_t state_q, state_d;
   logic [1:0] sel_q, gsel, sel;
   logic [3:0] grnt, awvalid, wvalid, wlast, bready, aw_route, w_route, b_route;
   logic [3:0][ID_WIDTH-1:0] awid;
   logic [3:0][ADDR_WIDTH-1:0] awaddr;
   logic [3:0][7:0] awlen;
   logic [3:0][2:0] awsize;
   logic [3:0][1:0] awburst;
   logic [3:0][DATA_WIDTH-1:0] wdata;
   logic [3:0][DATA_WIDTH/8-1:0] wstrb;
   logic gvalid, aw_hs, w_hs, b_hs, wlast_out;

   assign grnt    = {m3_wgrnt, m2_wgrnt, m1_wgrnt, m0_wgrnt};
   assign awid    = {m3_AWID, m2_AWID, m1_AWID, m0_AWID};
   assign awaddr  = {m3_AWADDR, m2_AWADDR, m1_AWADDR, m0_AWADDR};
   assign awlen   = {m3_AWLEN, m2_AWLEN, m1_AWLEN, m0_AWLEN};
   assign awsize  = {m3_AWSIZE, m2_AWSIZE, m1_AWSIZE, m0_AWSIZE};
   assign awburst = {m3_AWBURST, m2_AWBURST, m1_AWBURST, m0_AWBURST};
   assign awvalid = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};
   assign wdata   = {m3_WDATA, m2_WDATA, m1_WDATA, m0_WDATA};
   assign wstrb   = {m3_WSTRB, m2_WSTRB, m1_WSTRB, m0_WSTRB};
   assign wlast   = {m3_WLAST, m2_WLAST, m1_WLAST, m0_WLAST};
   assign wvalid  = {m3_WVALID, m2_WVALID, m1_WVALID, m0_WVALID};
   assign bready  = {m3_BREADY, m2_BREADY, m1_BREADY, m0_BREADY};

   // A zero or multi-hot grant selects nobody; gsel is only meaningful when gvalid.
   assign gvalid = (grnt != 4'd0) && ((grnt & (grnt - 4'd1)) == 4'd0);
   assign gsel   = {grnt[3] | grnt[2], grnt[3] | grnt[1]};
   assign sel    = (state_q == IDLE) ? gsel : sel_q;

   // One-hot per-channel routes: at most one master sees any channel at a time.
   assign aw_route = (state_q == IDLE && gvalid) ? 4'b0001 << sel : 4'd0;
   assign w_route  = (state_q == DATA) ? 4'b0001 << sel : 4'd0;
   assign b_route  = (state_q == RESP) ? 4'b0001 << sel : 4'd0;

   assign bus_AWVALID = |(aw_route & awvalid);
   assign bus_AWID    = |aw_route ? awid[sel] : '0;
   assign bus_AWADDR  = |aw_route ? awaddr[sel] : '0;
   assign bus_AWLEN   = |aw_route ? awlen[sel] : '0;
   assign bus_AWSIZE  = |aw_route ? awsize[sel] : '0;
   assign bus_AWBURST = |aw_route ? awburst[sel] : '0;
   assign {m3_AWREADY, m2_AWREADY, m1_AWREADY, m0_AWREADY} = aw_route & {4{bus_AWREADY}};

   assign bus_WVALID = |(w_route & wvalid);
   assign bus_WDATA  = |w_route ? wdata[sel] : '0;
   assign bus_WSTRB  = |w_route ? wstrb[sel] : '0;
   assign bus_WLAST  = wlast_out;
   assign {m3_WREADY, m2_WREADY, m1_WREADY, m0_WREADY} = w_route & {4{bus_WREADY}};

   assign bus_BREADY = |(b_route & bready);
   assign {m3_BVALID, m2_BVALID, m1_BVALID, m0_BVALID} = b_route & {4{bus_BVALID}};
   assign m0_BID   = b_route[0] ? bus_BID : '0;
   assign m1_BID   = b_route[1] ? bus_BID : '0;
   assign m2_BID   = b_route[2] ? bus_BID : '0;
   assign m3_BID   = b_route[3] ? bus_BID : '0;
   assign m0_BRESP = b_route[0] ? bus_BRESP : '0;
   assign m1_BRESP = b_route[1] ? bus_BRESP : '0;
   assign m2_BRESP = b_route[2] ? bus_BRESP : '0;
   assign m3_BRESP = b_route[3] ? bus_BRESP : '0;

   // Each handshake can only occur in its own state because the valids are routed by state.
   assign aw_hs = bus_AWVALID & bus_AWREADY;
   assign w_hs  = bus_WVALID & bus_WREADY;
   assign b_hs  = bus_BVALID & bus_BREADY;
   assign busy  = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      state_d = aw_hs ? DATA : (w_hs && wlast_out) ? RESP : b_hs ? IDLE : state_q;
   end

   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         if (aw_hs) sel_q <= gsel;
      end

`ifdef AXI_MUX_W_BEATCHK_EN
   logic [7:0] beat_cnt, len_q;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         beat_cnt <= '0;
         len_q    <= '0;
      end else if (aw_hs) begin
         beat_cnt <= '0;
         len_q    <= awlen[sel];
      end else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
   // The counted last beat, not the master's WLAST, closes the burst.
   assign wlast_out = (state_q == DATA) && (beat_cnt == len_q);
   assign err_wlast = w_hs && ((|(w_route & wlast)) != (beat_cnt == len_q));
`else
   assign wlast_out = |(w_route & wlast);
   assign err_wlast = 1'b0;
`endif
endmodule

// File: tb/tb_axi_mux_w.sv
// tb_axi_mux_w: randomized transaction-level checking of axi_mux_w against a phase-based model.
module tb_axi_mux_w;
   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;
   int vectors = 0;
   int miscompares = 0;
   logic [3:0] wgrnt, awvalid, wlast, wvalid, bready;
   logic [3:0][3:0] awid, wstrb;
   logic [3:0][31:0] awaddr, wdata;
   logic [3:0][7:0] awlen;
   logic [3:0][2:0] awsize;
   logic [3:0][1:0] awburst;
   wire [3:0] awready, wready, bvalid;
   wire [3:0][3:0] bid;
   wire [3:0][1:0] bresp;
   logic bus_AWREADY, bus_WREADY, bus_BVALID;
   logic [3:0] bus_BID;
   logic [1:0] bus_BRESP;
   wire [3:0] bus_AWID, bus_WSTRB;
   wire [31:0] bus_AWADDR, bus_WDATA;
   wire [7:0] bus_AWLEN;
   wire [2:0] bus_AWSIZE;
   wire [1:0] bus_AWBURST;
   wire bus_AWVALID, bus_WLAST, bus_WVALID, bus_BREADY, busy, err_wlast;
   wire [23:0] got_b = {bid[3], bresp[3], bid[2], bresp[2], bid[1], bresp[1], bid[0], bresp[0]};

   axi_mux_w dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m0_wgrnt(wgrnt[0]), .m0_AWID(awid[0]), .m0_AWADDR(awaddr[0]), .m0_AWLEN(awlen[0]),
      .m0_AWSIZE(awsize[0]), .m0_AWBURST(awburst[0]), .m0_AWVALID(awvalid[0]), .m0_AWREADY(awready[0]),
      .m0_WDATA(wdata[0]), .m0_WSTRB(wstrb[0]), .m0_WLAST(wlast[0]), .m0_WVALID(wvalid[0]),
      .m0_WREADY(wready[0]), .m0_BID(bid[0]), .m0_BRESP(bresp[0]), .m0_BVALID(bvalid[0]), .m0_BREADY(bready[0]),
      .m1_wgrnt(wgrnt[1]), .m1_AWID(awid[1]), .m1_AWADDR(awaddr[1]), .m1_AWLEN(awlen[1]),
      .m1_AWSIZE(awsize[1]), .m1_AWBURST(awburst[1]), .m1_AWVALID(awvalid[1]), .m1_AWREADY(awready[1]),
      .m1_WDATA(wdata[1]), .m1_WSTRB(wstrb[1]), .m1_WLAST(wlast[1]), .m1_WVALID(wvalid[1]),
      .m1_WREADY(wready[1]), .m1_BID(bid[1]), .m1_BRESP(bresp[1]), .m1_BVALID(bvalid[1]), .m1_BREADY(bready[1]),
      .m2_wgrnt(wgrnt[2]), .m2_AWID(awid[2]), .m2_AWADDR(awaddr[2]), .m2_AWLEN(awlen[2]),
      .m2_AWSIZE(awsize[2]), .m2_AWBURST(awburst[2]), .m2_AWVALID(awvalid[2]), .m2_AWREADY(awready[2]),
      .m2_WDATA(wdata[2]), .m2_WSTRB(wstrb[2]), .m2_WLAST(wlast[2]), .m2_WVALID(wvalid[2]),
      .m2_WREADY(wready[2]), .m2_BID(bid[2]), .m2_BRESP(bresp[2]), .m2_BVALID(bvalid[2]), .m2_BREADY(bready[2]),
      .m3_wgrnt(wgrnt[3]), .m3_AWID(awid[3]), .m3_AWADDR(awaddr[3]), .m3_AWLEN(awlen[3]),
      .m3_AWSIZE(awsize[3]), .m3_AWBURST(awburst[3]), .m3_AWVALID(awvalid[3]), .m3_AWREADY(awready[3]),
      .m3_WDATA(wdata[3]), .m3_WSTRB(wstrb[3]), .m3_WLAST(wlast[3]), .m3_WVALID(wvalid[3]),
      .m3_WREADY(wready[3]), .m3_BID(bid[3]), .m3_BRESP(bresp[3]), .m3_BVALID(bvalid[3]), .m3_BREADY(bready[3]),
      .bus_AWID(bus_AWID), .bus_AWADDR(bus_AWADDR), .bus_AWLEN(bus_AWLEN), .bus_AWSIZE(bus_AWSIZE),
      .bus_AWBURST(bus_AWBURST), .bus_AWVALID(bus_AWVALID), .bus_AWREADY(bus_AWREADY),
      .bus_WDATA(bus_WDATA), .bus_WSTRB(bus_WSTRB), .bus_WLAST(bus_WLAST), .bus_WVALID(bus_WVALID),
      .bus_WREADY(bus_WREADY), .bus_BID(bus_BID), .bus_BRESP(bus_BRESP), .bus_BVALID(bus_BVALID),
      .bus_BREADY(bus_BREADY), .busy(busy), .err_wlast(err_wlast)
   );

   task automatic idle_inputs();
      wgrnt = '0; awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
      bus_AWREADY = 1'b0; bus_WREADY = 1'b0; bus_BVALID = 1'b0; bus_BID = '0; bus_BRESP = '0;
   endtask

   // Model: phase 0 = address, 1 = data, 2 = response, 3 = done. alt: 0 keep grant,
   // 1 switch grant to the next master, 2 random grant once the address is accepted.
   task automatic run_txn(input int m, input int len, input int bwait, input int bhold, input bit lazy,
                          input int alt, input int bad, input int rst_beat, output int busy_n);
      logic [31:0] d[$];
      logic [31:0] addr;
      logic [3:0] id, strb, exp_awr, exp_wr, exp_bv;
      logic [1:0] resp;
      logic [23:0] exp_b;
      int phase, sent, cyc, bw, bh;
      bit aw_hs, w_hs, b_hs, exp_wv, exp_err;
      for (int i = 0; i <= len; i++) d.push_back($urandom);
      id = 4'($urandom); addr = $urandom; resp = 2'($urandom); strb = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
         awid[j] = 4'($urandom); awaddr[j] = $urandom; awlen[j] = 8'($urandom);
         awsize[j] = 3'($urandom); awburst[j] = 2'($urandom);
      end
      awid[m] = id; awaddr[m] = addr; awlen[m] = 8'(len); awsize[m] = 3'd2; awburst[m] = 2'd1; wstrb[m] = strb;
      phase = 0; sent = 0; cyc = 0; busy_n = 0; bw = bwait; bh = bhold;
      while (phase != 3) begin
         if (cyc++ == 400) begin
            vectors++; miscompares++;
            $display("FAIL txn_timeout m=%0d phase=%0d got no completion, required completion", m, phase);
            break;
         end
         for (int j = 0; j < 4; j++) if (j != m) begin
            awvalid[j] = 1'($urandom); wvalid[j] = 1'($urandom); wlast[j] = 1'($urandom);
            bready[j] = 1'($urandom); wdata[j] = $urandom; wstrb[j] = 4'($urandom);
         end
         wgrnt = (phase == 0 || alt == 0) ? 4'b0001 << m : (alt == 1) ? 4'b0001 << ((m + 1) % 4) : 4'($urandom);
         awvalid[m] = (phase == 0);
         wvalid[m] = (phase == 0) ? 1'($urandom) : (phase == 1) && (!lazy || 1'($urandom));
         wdata[m] = d[sent > len ? len : sent];
         wlast[m] = (sent == len) ^ (sent == bad);
         bready[m] = (phase == 2) ? (bh == 0 && (!lazy || 1'($urandom))) : 1'($urandom);
         bus_AWREADY = !lazy || 1'($urandom);
         bus_WREADY = !lazy || 1'($urandom);
         bus_BVALID = (phase == 2) && bw == 0;
         bus_BID = id; bus_BRESP = resp;
         if (phase == 1 && sent == rst_beat) begin
            ARESETn = 1'b0; wgrnt = '0; #1;
            vectors++;
            if ({busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid} !== 17'd0) begin
               miscompares++;
               $display("FAIL reset_mid got %b required 0", {busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid});
            end
            @(negedge ACLK); ARESETn = 1'b1;
            @(posedge ACLK); #1;
            break;
         end
         @(negedge ACLK);
         aw_hs = (phase == 0) && bus_AWREADY;
         exp_wv = (phase == 1) && wvalid[m];
         w_hs = exp_wv && bus_WREADY;
         b_hs = (phase == 2) && bus_BVALID && bready[m];
         exp_awr = aw_hs ? 4'b0001 << m : 4'd0;
         exp_wr = (phase == 1 && bus_WREADY) ? 4'b0001 << m : 4'd0;
         exp_bv = (phase == 2 && bus_BVALID) ? 4'b0001 << m : 4'd0;
         exp_b = 24'({id, resp}) << (6 * m);
`ifdef AXI_MUX_W_BEATCHK_EN
         exp_err = w_hs && (wlast[m] != (sent == len));
`else
         exp_err = 1'b0;
`endif
         vectors++;
         if ({bus_AWVALID, awready} !== {phase == 0, exp_awr}) begin
            miscompares++;
            $display("FAIL aw_route m=%0d phase=%0d got %b required %b", m, phase, {bus_AWVALID, awready}, {phase == 0, exp_awr});
         end
         if (phase == 0) begin
            vectors++;
            if ({bus_AWID, bus_AWADDR, bus_AWLEN, bus_AWSIZE, bus_AWBURST} !== {id, addr, 8'(len), 3'd2, 2'd1}) begin
               miscompares++;
               $display("FAIL aw_fields m=%0d got %h/%h/%0d required %h/%h/%0d", m, bus_AWID, bus_AWADDR, bus_AWLEN, id, addr, len);
            end
         end
         vectors++;
         if ({bus_WVALID, wready} !== {exp_wv, exp_wr}) begin
            miscompares++;
            $display("FAIL w_route m=%0d phase=%0d beat=%0d got %b required %b", m, phase, sent, {bus_WVALID, wready}, {exp_wv, exp_wr});
         end
         if (exp_wv) begin
            vectors++;
            if ({bus_WDATA, bus_WSTRB, bus_WLAST} !== {d[sent > len ? len : sent], strb, sent == len}) begin
               miscompares++;
               $display("FAIL w_beat m=%0d beat=%0d got %h/%h/%b required %h/%h/%b", m, sent, bus_WDATA, bus_WSTRB, bus_WLAST,
                        d[sent > len ? len : sent], strb, sent == len);
            end
         end
         vectors++;
         if ({bus_BREADY, bvalid} !== {(phase == 2) && bready[m], exp_bv}) begin
            miscompares++;
            $display("FAIL b_route m=%0d phase=%0d got %b required %b", m, phase, {bus_BREADY, bvalid}, {(phase == 2) && bready[m], exp_bv});
         end
         if (phase == 2) begin
            vectors++;
            if (got_b !== exp_b) begin
               miscompares++;
               $display("FAIL b_fields m=%0d got %h required %h", m, got_b, exp_b);
            end
         end
         vectors++;
         if ({busy, err_wlast} !== {phase != 0, exp_err}) begin
            miscompares++;
            $display("FAIL busy_err m=%0d phase=%0d beat=%0d got %b required %b", m, phase, sent, {busy, err_wlast}, {phase != 0, exp_err});
         end
         busy_n += int'(busy);
         @(posedge ACLK); #1;
         if (aw_hs) phase = 1;
         else if (w_hs) begin
            if (sent == len) phase = 2;
            sent++;
         end else if (phase == 2) begin
            if (b_hs) phase = 3;
            else if (bus_BVALID && bh > 0) bh--;
            if (bw > 0) bw--;
         end
      end
      idle_inputs();
      @(negedge ACLK);
      vectors++;
      if ({busy, bus_AWVALID, bus_WVALID, bus_BREADY} !== 4'd0) begin
         miscompares++;
         $display("FAIL txn_end m=%0d got %b required 0000", m, {busy, bus_AWVALID, bus_WVALID, bus_BREADY});
      end
      @(posedge ACLK); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      repeat (2) @(negedge ACLK);
      vectors++;
      if ({busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid} !== 17'd0) begin
         miscompares++;
         $display("FAIL reset_hold got %b required 0", {busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid});
      end
      ARESETn = 1'b1;
      @(posedge ACLK); #1;
      @(negedge ACLK);
      vectors++;
      if ({busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY} !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_release got %b required 0", {busy, err_wlast, bus_AWVALID, bus_WVALID, bus_BREADY});
      end
      @(posedge ACLK); #1;
   endtask

   task automatic test_basic();
      int n;
      run_txn(1, 3, 1, 0, 1'b0, 0, -1, -1, n);
      vectors++;
      if (n !== 6) begin
         miscompares++;
         $display("FAIL basic_busy_cycles got %0d required 6", n);
      end
   endtask

   task automatic test_invalid_grant();
      logic [3:0] mh [5] = '{4'b0011, 4'b1100, 4'b0101, 4'b1111, 4'b0110};
      awvalid = '1; wvalid = '1; bready = '1; wlast = '1;
      bus_AWREADY = 1'b1; bus_WREADY = 1'b1; bus_BVALID = 1'b1;
      for (int c = 0; c < 10; c++) begin
         wgrnt = (c < 5) ? mh[c] : 4'd0;
         @(negedge ACLK);
         vectors++;
         if ({bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid, busy} !== 16'd0) begin
            miscompares++;
            $display("FAIL invalid_grant grant=%b got %b required 0", wgrnt, {bus_AWVALID, bus_WVALID, bus_BREADY, awready, wready, bvalid, busy});
         end
         @(posedge ACLK); #1;
      end
      idle_inputs();
   endtask

   task automatic test_idle_reroute();
      int k;
      awvalid = '1; wvalid = '1; bus_AWREADY = 1'b0;
      for (int j = 0; j < 4; j++) awaddr[j] = $urandom;
      for (int c = 0; c < 8; c++) begin
         k = $urandom_range(0, 3);
         wgrnt = 4'b0001 << k;
         @(negedge ACLK);
         vectors++;
         if ({bus_AWVALID, bus_AWADDR, awready, busy} !== {1'b1, awaddr[k], 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_reroute m=%0d got %b/%h required 1/%h", k, bus_AWVALID, bus_AWADDR, awaddr[k]);
         end
         @(posedge ACLK); #1;
      end
      idle_inputs();
   endtask

   task automatic test_grant_switch();
      int n;
      run_txn(1, 3, 0, 0, 1'b0, 1, -1, -1, n);
      run_txn(2, 2, 0, 0, 1'b0, 0, -1, -1, n);
   endtask

   task automatic test_bready_hold();
      int n;
      run_txn(0, 1, 0, 3, 1'b0, 0, -1, -1, n);
   endtask

   task automatic test_reset_mid();
      int n;
      run_txn(1, 3, 0, 0, 1'b0, 0, -1, 2, n);
      run_txn(3, 2, 0, 0, 1'b0, 0, -1, -1, n);
   endtask

   task automatic test_random();
      int n;
      for (int t = 0; t < 30; t++)
         run_txn($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 2),
                 1'b1, $urandom_range(0, 2), -1, -1, n);
   endtask

`ifdef AXI_MUX_W_BEATCHK_EN
   task automatic test_beatchk();
      int n;
      run_txn(2, 1, 0, 0, 1'b0, 0, 0, -1, n);
   endtask
`endif

   initial begin
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
      idle_inputs();
      @(posedge ACLK); #1;
      test_reset();
      test_basic();
      test_invalid_grant();
      test_idle_reroute();
      test_grant_switch();
      test_bready_hold();
      test_reset_mid();
`ifdef AXI_MUX_W_BEATCHK_EN
      test_beatchk();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axi_mux_w.md
# axi_mux_w

Write-channel master multiplexer that sits directly downstream of the write arbiter in the AXI4 interconnect. It consumes the one-hot write grants and routes the granted master's AW, W and B channels onto the single shared slave-side write bus. From the AW handshake until the B handshake it holds the route in its own state machine, so a mid-burst grant change cannot corrupt a transaction. It also counts W beats against AWLEN.

## Interface
- ADDR_WIDTH, 32, AWADDR width
- DATA_WIDTH, 32, WDATA width; WSTRB is DATA_WIDTH/8
- ID_WIDTH, 4, AWID/BID width
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- mN_wgrnt  in  1  write grant from arbiter, N=0..3, expected one-hot or zero
- mN_AWID / mN_AWADDR / mN_AWLEN / mN_AWSIZE / mN_AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  master N write address
- mN_AWVALID  in  1  master N address valid
- mN_AWREADY  out  1  address ready to master N
- mN_WDATA / mN_WSTRB / mN_WLAST / mN_WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  master N write data
- mN_WREADY  out  1  data ready to master N
- mN_BID / mN_BRESP / mN_BVALID  out  ID_WIDTH/2/1  response to master N
- mN_BREADY  in  1  master N response ready
- bus_AW* / bus_AWVALID  out  as above  shared address channel
- bus_AWREADY  in  1  shared address ready; also fed to the arbiter as m_AWREADY
- bus_W* / bus_WVALID  out  as above  shared data channel
- bus_WREADY  in  1  shared data ready; also fed to the arbiter as m_WREADY
- bus_BID / bus_BRESP / bus_BVALID  in  ID_WIDTH/2/1  shared response; bus_BVALID also fed to the arbiter as m_BVALID
- bus_BREADY  out  1  shared response ready
- busy  out  1  high while state is not IDLE
- err_wlast  out  1  one-cycle pulse on a burst length mismatch (only when AXI_MUX_W_BEATCHK_EN is defined)

## Operation
- Select source:
  - In IDLE, sel = binary encode of the grant vector, computed combinationally.
  - In every other state, sel = the locked register sel_q.
- Valid grant: exactly one grant bit is high. A zero or multi-hot grant is treated as no master. In that case all bus valids are 0, all mN readys are 0, and bus_BREADY is 0.
- Unselected masters always see 0 on AWREADY, WREADY and BVALID. Their BID and BRESP outputs are 0.
- States and transitions:
  - IDLE: forward the selected master's AW to the bus, with mSEL_AWREADY = bus_AWREADY. On an AW handshake (bus_AWVALID & bus_AWREADY), latch sel_q = sel and beat_cnt = 0, then go to DATA. No W or B is forwarded in IDLE; W sent before AW is stalled.
  - DATA: forward W of master sel_q, with mSEL_WREADY = bus_WREADY. Each W handshake increments beat_cnt (8 bits). A handshake with the outgoing bus_WLAST = 1 moves to RESP.
  - RESP: set bus_BREADY = msel_q_BREADY and route bus_BID, bus_BRESP and bus_BVALID to master sel_q. On a B handshake, go to IDLE.
- The AW channel is blocked in DATA and RESP, so there is exactly one outstanding write.
- AWLEN is latched into len_q at the AW handshake.
- Reset mid-operation: the state returns to IDLE immediately and asynchronously. Any partial burst is abandoned and no error is flagged.

## Timing
- AW, W and B pass through combinationally with zero-cycle latency. Only the state, sel_q, len_q and beat_cnt registers are added.
- The state changes on the ACLK edge following a handshake. The next handshake in the new state can occur in that same cycle.
- Minimum transaction length is AWLEN+3 cycles: 1 AW cycle, AWLEN+1 W cycles, and 1 B cycle.
- Reset values:
  - state = IDLE; sel_q, len_q and beat_cnt = 0; busy = 0; err_wlast = 0.
  - All bus valids and bus_BREADY are 0 unless a grant is valid (combinational in IDLE).
- A grant change during DATA or RESP is ignored until the state returns to IDLE.
- A grant change during IDLE before the AW handshake re-routes in the same cycle.

## Configuration
- AXI_MUX_W_BEATCHK_EN defined:
  - bus_WLAST is driven as (beat_cnt == len_q); master WLAST is ignored for routing.
  - If master WLAST differs from (beat_cnt == len_q) on any W handshake, err_wlast pulses high for one cycle.
  - The burst ends on the counted last beat.
- AXI_MUX_W_BEATCHK_EN undefined:
  - bus_WLAST = mSEL_WLAST, passed through.
  - The DATA→RESP transition uses the master's WLAST.
  - err_wlast is tied to 0 and len_q is not instantiated.

## Test plan
- m1 grant=0100, m1 AWLEN=3 with bus always ready -> AW accepted at cycle 0, 4 W beats routed, BRESP=0 delivered to m1_BVALID. busy is high for exactly 6 cycles; m0, m2 and m3 readys stay 0 throughout.
- Grant switches from 0100 to 0010 during m1 DATA -> bus W stays sourced from m1 until WLAST; after the B handshake, m2's AW is forwarded.
- Grant 1100 (multi-hot) and 0000 -> bus_AWVALID=0 and all mN_AWREADY=0 for 10 cycles; the state remains IDLE.
- Macro defined: AWLEN=1, master asserts WLAST on beat 0 -> err_wlast pulses for 1 cycle; bus_WLAST is asserted on beat 1; the state reaches RESP after beat 1.
- ARESETn low during beat 2 of a 4-beat burst -> all outputs 0 and state IDLE within the same cycle; after release, a new m3 AW (grant 0001) completes normally.
- bus_BVALID held for 3 cycles with m0_BREADY=0, then 1 -> bus_BREADY follows m0_BREADY; the state stays RESP until the handshake, then returns to IDLE.
